ctrl_decode_stage: RTL and testbench

- Parametrised, pipelined successor to the combinational main-control decoder.
- Decodes the ID-stage instruction into control signals and registers them into the ID/EX control pipeline register.
- Detects load-use hazards and inserts a bubble. Honours external stall and branch flush.
- Optionally decodes JAL/JALR/LUI/AUIPC, flags illegal opcodes, and keeps a saturating hazard-stall counter.

---
 rtl/ctrl_decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_stage.sv
// ID-stage main-control decoder with a registered ID/EX control slot,
// load-use bubble insertion, external stall/flush and a saturating stall counter.
module ctrl_decode_stage #(
   parameter bit          EXT_OPS = 1'b1,
   parameter int unsigned RD_W    = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [31:0]      id_instr,
   input  logic             stall_ext,
   input  logic             flush,
   output logic             id_ready,
   output logic             hazard_stall,
   output logic             ex_valid,
   output logic             ex_reg_write,
   output logic             ex_alu_src,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_mem_to_reg,
   output logic             ex_branch,
   output logic             ex_jump,
   output logic             ex_jalr,
   output logic             ex_pc_rel,
   output logic [1:0]       ex_alu_op,
   output logic             ex_illegal,
   output logic [RD_W-1:0]  ex_rd,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       pc_rel;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   logic [6:0]      opcode;
   logic [RD_W-1:0] rs1;
   logic [RD_W-1:0] rs2;
   logic [RD_W-1:0] rd;
   ctrl_t           dec;
   logic            use_rs1;
   logic            use_rs2;

   ctrl_t            ctrl_q, ctrl_d;
   logic             valid_q, valid_d;
   logic [RD_W-1:0]  rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic unused_instr_bits;

   assign opcode = id_instr[6:0];
   assign rs1    = RD_W'(id_instr[19:15]);
   assign rs2    = RD_W'(id_instr[24:20]);
   assign rd     = RD_W'(id_instr[11:7]);
   assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

   // Opcode decode; extended opcodes fall into the illegal bucket when disabled.
   always_comb begin
      dec     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1; dec.alu_op = 2'b10;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_I: begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b10;
            use_rs1 = 1'b1;
         end
         OP_LOAD: begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
            dec.mem_to_reg = 1'b1; dec.alu_op = 2'b00;
            use_rs1 = 1'b1;
         end
         OP_STORE: begin
            dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = 2'b00;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_BR: begin
            dec.branch = 1'b1; dec.alu_op = 2'b01;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OP_JAL: begin
            if (EXT_OPS) begin
               dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_op = 2'b00;
            end else dec.illegal = 1'b1;
         end
         OP_JALR: begin
            if (EXT_OPS) begin
               dec.reg_write = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
               dec.alu_src = 1'b1; dec.alu_op = 2'b00;
               use_rs1 = 1'b1;
            end else dec.illegal = 1'b1;
         end
         OP_LUI: begin
            if (EXT_OPS) begin
               dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b11;
            end else dec.illegal = 1'b1;
         end
         OP_AUIPC: begin
            if (EXT_OPS) begin
               dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.pc_rel = 1'b1;
               dec.alu_op = 2'b00;
            end else dec.illegal = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // A load in EX whose destination feeds a source of the ID instruction forces a bubble.
   assign hazard_stall = id_valid & valid_q & ctrl_q.mem_read & (rd_q != '0) &
                         ((use_rs1 & (rs1 == rd_q)) | (use_rs2 & (rs2 == rd_q)));
   assign id_ready     = !hazard_stall & !stall_ext & !flush;

   // ID/EX next state: flush > external stall > hazard bubble > load.
   always_comb begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (flush) begin
         ctrl_d  = '0;
         valid_d = 1'b0;
         rd_d    = '0;
      end else if (!stall_ext) begin
         if (hazard_stall) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            rd_d    = '0;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         end else if (id_valid) begin
            ctrl_d  = dec;
            valid_d = 1'b1;
            rd_d    = rd;
         end else begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            rd_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= '0;
         valid_q <= 1'b0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_branch     = ctrl_q.branch;
   assign ex_jump       = ctrl_q.jump;
   assign ex_jalr       = ctrl_q.jalr;
   assign ex_pc_rel     = ctrl_q.pc_rel;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign ex_illegal    = ctrl_q.illegal;
   assign ex_rd         = rd_q;
   assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench: two decoder instances (full ops / 16-bit counter, and
// no extended ops / 2-bit counter) driven by the same directed vectors.
module tb_ctrl_decode_stage;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       pc_rel;
      logic [1:0] alu_op;
      logic       illegal;
      logic [4:0] rd;
   } exp_t;

   typedef struct {
      exp_t        ea;
      int unsigned ca;
      exp_t        eb;
      int unsigned cb;
   } rec_t;

   localparam logic [31:0] I_ADD3   = 32'h002081B3;
   localparam logic [31:0] I_LW5    = 32'h0000A283;
   localparam logic [31:0] I_ADD6   = 32'h00228333;
   localparam logic [31:0] I_LW0    = 32'h0000A003;
   localparam logic [31:0] I_ADD7X0 = 32'h000003B3;
   localparam logic [31:0] I_SW     = 32'h0020A023;
   localparam logic [31:0] I_BEQ    = 32'h00208063;
   localparam logic [31:0] I_ADDI4  = 32'h00108213;
   localparam logic [31:0] I_JAL1   = 32'h000000EF;
   localparam logic [31:0] I_JALR1  = 32'h000280E7;
   localparam logic [31:0] I_LUI10  = 32'h12345537;
   localparam logic [31:0] I_AUIPC2 = 32'h00000117;
   localparam logic [31:0] I_BAD10  = 32'h0000057F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        stall_ext;
   logic        flush;

   logic        rdy_a, haz_a, rdy_b, haz_b;
   exp_t        act_a, act_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   rec_t        sb[$];

   always #5 clk = ~clk;

   ctrl_decode_stage #(.EXT_OPS(1'b1), .RD_W(5), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .stall_ext(stall_ext), .flush(flush), .id_ready(rdy_a), .hazard_stall(haz_a),
      .ex_valid(act_a.valid), .ex_reg_write(act_a.reg_write), .ex_alu_src(act_a.alu_src),
      .ex_mem_read(act_a.mem_read), .ex_mem_write(act_a.mem_write),
      .ex_mem_to_reg(act_a.mem_to_reg), .ex_branch(act_a.branch), .ex_jump(act_a.jump),
      .ex_jalr(act_a.jalr), .ex_pc_rel(act_a.pc_rel), .ex_alu_op(act_a.alu_op),
      .ex_illegal(act_a.illegal), .ex_rd(act_a.rd), .stall_cnt(cnt_a)
   );

   ctrl_decode_stage #(.EXT_OPS(1'b0), .RD_W(5), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .stall_ext(stall_ext), .flush(flush), .id_ready(rdy_b), .hazard_stall(haz_b),
      .ex_valid(act_b.valid), .ex_reg_write(act_b.reg_write), .ex_alu_src(act_b.alu_src),
      .ex_mem_read(act_b.mem_read), .ex_mem_write(act_b.mem_write),
      .ex_mem_to_reg(act_b.mem_to_reg), .ex_branch(act_b.branch), .ex_jump(act_b.jump),
      .ex_jalr(act_b.jalr), .ex_pc_rel(act_b.pc_rel), .ex_alu_op(act_b.alu_op),
      .ex_illegal(act_b.illegal), .ex_rd(act_b.rd), .stall_cnt(cnt_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Hand-written expected ID/EX contents per instruction class.
   function automatic exp_t e_bub();
      exp_t e; e = '0; return e;
   endfunction
   function automatic exp_t e_r(input logic [4:0] rd);
      exp_t e; e = '0; e.valid = 1; e.reg_write = 1; e.alu_op = 2'b10; e.rd = rd; return e;
   endfunction
   function automatic exp_t e_i(input logic [4:0] rd);
      exp_t e; e = e_r(rd); e.alu_src = 1; return e;
   endfunction
   function automatic exp_t e_ld(input logic [4:0] rd);
      exp_t e; e = '0; e.valid = 1; e.reg_write = 1; e.alu_src = 1; e.mem_read = 1;
      e.mem_to_reg = 1; e.rd = rd; return e;
   endfunction
   function automatic exp_t e_st();
      exp_t e; e = '0; e.valid = 1; e.alu_src = 1; e.mem_write = 1; return e;
   endfunction
   function automatic exp_t e_br();
      exp_t e; e = '0; e.valid = 1; e.branch = 1; e.alu_op = 2'b01; return e;
   endfunction
   function automatic exp_t e_jal(input logic [4:0] rd);
      exp_t e; e = '0; e.valid = 1; e.reg_write = 1; e.jump = 1; e.rd = rd; return e;
   endfunction
   function automatic exp_t e_jalr(input logic [4:0] rd);
      exp_t e; e = e_jal(rd); e.jalr = 1; e.alu_src = 1; return e;
   endfunction
   function automatic exp_t e_lui(input logic [4:0] rd);
      exp_t e; e = '0; e.valid = 1; e.reg_write = 1; e.alu_src = 1; e.alu_op = 2'b11;
      e.rd = rd; return e;
   endfunction
   function automatic exp_t e_auipc(input logic [4:0] rd);
      exp_t e; e = '0; e.valid = 1; e.reg_write = 1; e.alu_src = 1; e.pc_rel = 1;
      e.rd = rd; return e;
   endfunction
   function automatic exp_t e_ill(input logic [4:0] rd);
      exp_t e; e = '0; e.valid = 1; e.illegal = 1; e.rd = rd; return e;
   endfunction

   // Drive one cycle of inputs, check the combinational outputs, queue the post-edge state.
   task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                       input logic e_haz, input exp_t ea, input int unsigned ca,
                       input exp_t eb, input int unsigned cb);
      rec_t r;
      @(negedge clk);
      id_valid = v; id_instr = ins; stall_ext = st; flush = fl;
      #1;
      check("hazard_a", 64'(haz_a), 64'(e_haz));
      check("ready_a", 64'(rdy_a), 64'(!e_haz && !st && !fl));
      check("hazard_b", 64'(haz_b), 64'(e_haz));
      check("ready_b", 64'(rdy_b), 64'(!e_haz && !st && !fl));
      r.ea = ea; r.ca = ca; r.eb = eb; r.cb = cb;
      sb.push_back(r);
   endtask

   // Monitor: compare the ID/EX slot against the scoreboard after every edge.
   initial begin
      rec_t r;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            r = sb.pop_front();
            check("ex_a", 64'(act_a), 64'(r.ea));
            check("cnt_a", 64'(cnt_a), 64'(r.ca));
            check("ex_b", 64'(act_b), 64'(r.eb));
            check("cnt_b", 64'(cnt_b), 64'(r.cb));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned ca;
      int unsigned cb;
      rst_n = 1'b0; id_valid = 1'b1; id_instr = I_ADD3; stall_ext = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_ex_a", 64'(act_a), 64'(0));
      check("rst_cnt_a", 64'(cnt_a), 64'(0));
      check("rst_ex_b", 64'(act_b), 64'(0));
      check("rst_cnt_b", 64'(cnt_b), 64'(0));
      rst_n = 1'b1;

      step(1, I_ADD3,   0, 0, 0, e_r(3),  0, e_r(3),  0);
      step(1, I_LW5,    0, 0, 0, e_ld(5), 0, e_ld(5), 0);
      step(1, I_ADD6,   0, 0, 1, e_bub(), 1, e_bub(), 1);
      step(1, I_ADD6,   0, 0, 0, e_r(6),  1, e_r(6),  1);
      step(1, I_LW0,    0, 0, 0, e_ld(0), 1, e_ld(0), 1);
      step(1, I_ADD7X0, 0, 0, 0, e_r(7),  1, e_r(7),  1);
      repeat (3) step(1, I_SW, 1, 0, 0, e_r(7), 1, e_r(7), 1);
      step(1, I_SW,     0, 0, 0, e_st(),  1, e_st(),  1);
      step(1, I_BEQ,    0, 0, 0, e_br(),  1, e_br(),  1);
      step(1, I_ADD3,   0, 0, 0, e_r(3),  1, e_r(3),  1);
      step(1, I_ADDI4,  1, 1, 0, e_bub(), 1, e_bub(), 1);
      step(1, I_ADDI4,  0, 0, 0, e_i(4),  1, e_i(4),  1);
      step(1, I_JAL1,   0, 0, 0, e_jal(1),   1, e_ill(1),  1);
      step(1, I_JALR1,  0, 0, 0, e_jalr(1),  1, e_ill(1),  1);
      step(1, I_LUI10,  0, 0, 0, e_lui(10),  1, e_ill(10), 1);
      step(1, I_AUIPC2, 0, 0, 0, e_auipc(2), 1, e_ill(2),  1);
      step(1, I_BAD10,  0, 0, 0, e_ill(10),  1, e_ill(10), 1);
      step(0, I_ADD3,   0, 0, 0, e_bub(), 1, e_bub(), 1);
      step(1, I_ADD3,   0, 1, 0, e_bub(), 1, e_bub(), 1);
      // Hazard masked by flush, then hazard held by external stall.
      step(1, I_LW5,    0, 0, 0, e_ld(5), 1, e_ld(5), 1);
      step(1, I_ADD6,   0, 1, 1, e_bub(), 1, e_bub(), 1);
      step(1, I_LW5,    0, 0, 0, e_ld(5), 1, e_ld(5), 1);
      step(1, I_ADD6,   1, 0, 1, e_ld(5), 1, e_ld(5), 1);
      step(1, I_ADD6,   0, 0, 1, e_bub(), 2, e_bub(), 2);
      step(1, I_ADD6,   0, 0, 0, e_r(6),  2, e_r(6),  2);
      ca = 2; cb = 2;
      for (int k = 0; k < 3; k++) begin
         step(1, I_LW5,  0, 0, 0, e_ld(5), ca, e_ld(5), cb);
         ca = ca + 1;
         cb = (cb < 3) ? cb + 1 : 3;
         step(1, I_ADD6, 0, 0, 1, e_bub(), ca, e_bub(), cb);
         step(1, I_ADD6, 0, 0, 0, e_r(6),  ca, e_r(6),  cb);
      end
      @(posedge clk);
      #2;
      check("sb_drain", 64'(sb.size()), 64'(0));
      check("sat_cnt_b", 64'(cnt_b), 64'(3));
      // Mid-operation asynchronous reset clears the slot without a clock edge.
      rst_n = 1'b0;
      #1;
      check("arst_ex_a", 64'(act_a), 64'(0));
      check("arst_cnt_a", 64'(cnt_a), 64'(0));
      check("arst_ex_b", 64'(act_b), 64'(0));
      check("arst_cnt_b", 64'(cnt_b), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
